// File: rtl/ccb_cmd_decoder_gen.sv
// ccb_cmd_decoder_gen
// Decodes active-low CCB command/data strobes from the backplane into
// one-cycle pulses, a RUN level, NSTR stretched reset pulses of programmable
// length and a captured data byte. Commands and data are taken only on the
// first cycle a strobe is seen asserted, so a long strobe acts once.
// The stretch channels and the RUN flop can be triplicated with majority
// voting, so that a single upset copy does not disturb SRST/RUN.
module ccb_cmd_decoder_gen #(
    parameter int                TMR       = 0,
    parameter int                NSTR      = 2,
    parameter logic [6*NSTR-1:0] STR_CODES = {6'h04, 6'h03},
    parameter int                CW        = 4,
    parameter int                STR_LEN   = 15
) (
    input  logic            CLKCMS,
    input  logic            RST,
    input  logic            CLKENAIN,
    input  logic            L1ARSTIN,
    input  logic            BXRSTIN,
    input  logic            BX0IN,
    input  logic            CMDSTRB,
    input  logic            DATASTRB,
    input  logic [5:0]      CCBCMD,
    input  logic [7:0]      CCBDATA,
    output logic            CLKENA,
    output logic            BX0,
    output logic            BXRST,
    output logic            L1ARST,
    output logic            BC0,
    output logic            START_TRG,
    output logic            STOP_TRG,
    output logic            RUN,
    output logic [2:0]      TTCCAL,
    output logic [NSTR-1:0] SRST,
    output logic [7:0]      DATA,
    output logic            DATA_VLD,
    output logic            DATA_RST
);

    localparam int            NCOPY    = (TMR != 0) ? 3 : 1;
    localparam logic [CW-1:0] STR_LAST = CW'(STR_LEN);

    localparam logic [5:0] CMD_BC0    = 6'h01;
    localparam logic [5:0] CMD_START  = 6'h06;
    localparam logic [5:0] CMD_STOP   = 6'h07;
    localparam logic [5:0] CMD_TTC0   = 6'h14;
    localparam logic [5:0] CMD_TTC1   = 6'h15;
    localparam logic [5:0] CMD_TTC2   = 6'h16;
    localparam logic [7:0] DATA_RST0  = 8'h54;
    localparam logic [7:0] DATA_RST1  = 8'h55;

    typedef enum logic {
        STR_IDLE   = 1'b0,
        STR_ACTIVE = 1'b1
    } strState_t;

    function automatic logic maj1(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CW-1:0] majVec(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b,
                                             input logic [CW-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic       clkEna_q, bx0_q, bxRst_q, l1aRst_q;
    logic       cmdStrb_q, cmdStrbPrev_q, dataStrb_q, dataStrbPrev_q;
    logic [5:0] cmd_q;
    logic [7:0] data_q;
    logic       cmdTake, dataTake;

    logic       bc0_q, start_q, stop_q, dataVld_q, dataRst_q;
    logic [2:0] ttcCal_q;
    logic [7:0] dataOut_q;

    logic       run_q [NCOPY];
    logic       runV, run_d;

    // Input flops: invert pins to true polarity; strobe history resets to
    // "already seen" so a strobe held through reset is not taken again.
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            clkEna_q       <= 1'b0;
            bx0_q          <= 1'b0;
            bxRst_q        <= 1'b0;
            l1aRst_q       <= 1'b0;
            cmdStrb_q      <= 1'b1;
            cmdStrbPrev_q  <= 1'b1;
            dataStrb_q     <= 1'b1;
            dataStrbPrev_q <= 1'b1;
            cmd_q          <= '0;
            data_q         <= '0;
        end else begin
            clkEna_q       <= ~CLKENAIN;
            bx0_q          <= ~BX0IN;
            bxRst_q        <= ~BXRSTIN;
            l1aRst_q       <= ~L1ARSTIN;
            cmdStrb_q      <= ~CMDSTRB;
            cmdStrbPrev_q  <= cmdStrb_q;
            dataStrb_q     <= ~DATASTRB;
            dataStrbPrev_q <= dataStrb_q;
            cmd_q          <= ~CCBCMD;
            data_q         <= ~CCBDATA;
        end
    end

    assign cmdTake  = cmdStrb_q & ~cmdStrbPrev_q;
    assign dataTake = dataStrb_q & ~dataStrbPrev_q;

    // One-cycle command pulses and data capture, registered one edge after sampling.
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            bc0_q     <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            ttcCal_q  <= '0;
            dataVld_q <= 1'b0;
            dataRst_q <= 1'b0;
            dataOut_q <= '0;
        end else begin
            bc0_q       <= cmdTake && (cmd_q == CMD_BC0);
            start_q     <= cmdTake && (cmd_q == CMD_START);
            stop_q      <= cmdTake && (cmd_q == CMD_STOP);
            ttcCal_q[0] <= cmdTake && (cmd_q == CMD_TTC0);
            ttcCal_q[1] <= cmdTake && (cmd_q == CMD_TTC1);
            ttcCal_q[2] <= cmdTake && (cmd_q == CMD_TTC2);
            dataVld_q   <= dataTake;
            dataRst_q   <= dataTake && ((data_q == DATA_RST0) || (data_q == DATA_RST1));
            if (dataTake) begin
                dataOut_q <= data_q;
            end
        end
    end

    if (TMR != 0) begin : g_runVote
        assign runV = maj1(run_q[0], run_q[1], run_q[2]);
    end else begin : g_runSingle
        assign runV = run_q[0];
    end

    // RUN next state from the voted level: set by start, cleared by stop.
    always_comb begin
        run_d = runV;
        if (cmdTake && (cmd_q == CMD_START)) begin
            run_d = 1'b1;
        end else if (cmdTake && (cmd_q == CMD_STOP)) begin
            run_d = 1'b0;
        end
    end

    // RUN copies all reload from the voted next state, scrubbing any upset.
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NCOPY; c++) run_q[c] <= 1'b0;
        end else begin
            for (int c = 0; c < NCOPY; c++) run_q[c] <= run_d;
        end
    end

    for (genvar i = 0; i < NSTR; i++) begin : g_chan
        strState_t     state_q [NCOPY];
        logic [CW-1:0] cnt_q   [NCOPY];
        strState_t     stateV, state_d;
        logic [CW-1:0] cntV, cnt_d;
        logic          trig;

        assign trig = cmdTake && (cmd_q == STR_CODES[6*i +: 6]);

        if (TMR != 0) begin : g_vote
            assign stateV = strState_t'(maj1(state_q[0], state_q[1], state_q[2]));
            assign cntV   = majVec(cnt_q[0], cnt_q[1], cnt_q[2]);
        end else begin : g_single
            assign stateV = state_q[0];
            assign cntV   = cnt_q[0];
        end

        // Stretch FSM: trigger (or retrigger) restarts the count; the pulse
        // ends synchronously once the count reaches STR_LAST.
        always_comb begin
            state_d = stateV;
            cnt_d   = cntV;
            if (stateV == STR_IDLE) begin
                if (trig) begin
                    state_d = STR_ACTIVE;
                    cnt_d   = '0;
                end
            end else begin
                if (trig) begin
                    cnt_d = '0;
                end else if (cntV == STR_LAST) begin
                    state_d = STR_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntV + 1'b1;
                end
            end
        end

        // Stretch state/counter copies, all loaded from the voted next state.
        always_ff @(posedge CLKCMS or posedge RST) begin
            if (RST) begin
                for (int c = 0; c < NCOPY; c++) begin
                    state_q[c] <= STR_IDLE;
                    cnt_q[c]   <= '0;
                end
            end else begin
                for (int c = 0; c < NCOPY; c++) begin
                    state_q[c] <= state_d;
                    cnt_q[c]   <= cnt_d;
                end
            end
        end

        assign SRST[i] = (stateV == STR_ACTIVE);
    end

    assign CLKENA    = clkEna_q;
    assign BX0       = bx0_q;
    assign BXRST     = bxRst_q;
    assign L1ARST    = l1aRst_q;
    assign BC0       = bc0_q;
    assign START_TRG = start_q;
    assign STOP_TRG  = stop_q;
    assign RUN       = runV;
    assign TTCCAL    = ttcCal_q;
    assign DATA      = dataOut_q;
    assign DATA_VLD  = dataVld_q;
    assign DATA_RST  = dataRst_q;

endmodule

// File: tb/tb_ccb_cmd_decoder_gen.sv
// tb_ccb_cmd_decoder_gen
// Directed bench for ccb_cmd_decoder_gen with default parameters: a vector
// table for single-strobe decode, then hand-written sequences for held
// strobes, stretched pulses with retrigger, reset mid-pulse and unused codes.
`timescale 1ns/1ps
module tb_ccb_cmd_decoder_gen;

    logic       clkCms = 1'b0;
    logic       rst;
    logic       clkEnaIn, l1aRstIn, bxRstIn, bx0In, cmdStrbN, dataStrbN;
    logic [5:0] ccbCmdN;
    logic [7:0] ccbDataN;
    logic       clkEna, bx0, bxRst, l1aRst, bc0, startTrg, stopTrg, run;
    logic [2:0] ttcCal;
    logic [1:0] srst;
    logic [7:0] dataOut;
    logic       dataVld, dataRst;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       cmdStrb;
        logic [5:0] cmd;
        logic       dataStrb;
        logic [7:0] data;
        logic [2:0] expCmdPulse;
        logic [2:0] expTtc;
        logic       expRun;
        logic       expVld;
        logic       expDrst;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [15];

    ccb_cmd_decoder_gen dut (
        .CLKCMS    (clkCms),
        .RST       (rst),
        .CLKENAIN  (clkEnaIn),
        .L1ARSTIN  (l1aRstIn),
        .BXRSTIN   (bxRstIn),
        .BX0IN     (bx0In),
        .CMDSTRB   (cmdStrbN),
        .DATASTRB  (dataStrbN),
        .CCBCMD    (ccbCmdN),
        .CCBDATA   (ccbDataN),
        .CLKENA    (clkEna),
        .BX0       (bx0),
        .BXRST     (bxRst),
        .L1ARST    (l1aRst),
        .BC0       (bc0),
        .START_TRG (startTrg),
        .STOP_TRG  (stopTrg),
        .RUN       (run),
        .TTCCAL    (ttcCal),
        .SRST      (srst),
        .DATA      (dataOut),
        .DATA_VLD  (dataVld),
        .DATA_RST  (dataRst)
    );

    // 40 MHz CMS clock.
    always #12.5 clkCms = ~clkCms;

    // Packs the decoded outputs as {BC0,START,STOP,RUN,TTCCAL,VLD,DRST,DATA,SRST}.
    function automatic logic [31:0] observed();
        return {13'd0, bc0, startTrg, stopTrg, run, ttcCal, dataVld, dataRst, dataOut, srst};
    endfunction

    function automatic logic [31:0] packExp(input logic [2:0] cmdPulse, input logic runLvl,
                                            input logic [2:0] ttc, input logic vld,
                                            input logic drst, input logic [7:0] d,
                                            input logic [1:0] s);
        return {13'd0, cmdPulse, runLvl, ttc, vld, drst, d, s};
    endfunction

    task automatic step();
        @(posedge clkCms);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the strobes/buses in true polarity; pins are active low.
    task automatic applyStimulus(input logic cs, input logic [5:0] c,
                                 input logic ds, input logic [7:0] d);
        cmdStrbN  = ~cs;
        ccbCmdN   = ~c;
        dataStrbN = ~ds;
        ccbDataN  = ~d;
    endtask

    function automatic bit isUsedCode(input logic [5:0] c);
        return (c == 6'h01) || (c == 6'h06) || (c == 6'h07) || (c == 6'h14) ||
               (c == 6'h15) || (c == 6'h16) || (c == 6'h03) || (c == 6'h04);
    endfunction

    // One strobe on cycle 0 (and optionally cycle 10), then counts how long SRST[ch] stays high.
    task automatic runStretch(input string name, input int ch, input logic [5:0] code,
                              input bit retrig, input int expHigh);
        int  highCnt  = 0;
        int  rises    = 0;
        int  otherCnt = 0;
        bit  prev     = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            applyStimulus((cyc == 0) || (retrig && cyc == 10), code, 1'b0, 8'h00);
            step();
            if (srst[ch]) highCnt++;
            if (srst[ch] && !prev) rises++;
            if (srst[1-ch]) otherCnt++;
            prev = srst[ch];
        end
        checkOutput({name, "_width"}, 32'(highCnt), 32'(expHigh));
        checkOutput({name, "_rises"}, 32'(rises), 32'd1);
        checkOutput({name, "_other"}, 32'(otherCnt), 32'd0);
    endtask

    initial begin
        int          pulseCnt;
        int          seenAt;
        logic [5:0]  code;
        logic [31:0] acc;

        rst = 1'b1;
        clkEnaIn = 1'b1; l1aRstIn = 1'b1; bxRstIn = 1'b1; bx0In = 1'b1;
        applyStimulus(1'b0, 6'h00, 1'b0, 8'h00);

        //               cs  cmd    ds  data    pulse   ttc     run vld drst data
        vecs[0]  = '{1'b1, 6'h01, 1'b0, 8'h00, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 6'h06, 1'b0, 8'h00, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 6'h14, 1'b0, 8'h00, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 6'h15, 1'b0, 8'h00, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 6'h16, 1'b0, 8'h00, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 6'h07, 1'b0, 8'h00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 6'h00, 1'b1, 8'h55, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 8'h55};
        vecs[7]  = '{1'b0, 6'h00, 1'b1, 8'h56, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 8'h56};
        vecs[8]  = '{1'b0, 6'h00, 1'b1, 8'h54, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 8'h54};
        vecs[9]  = '{1'b1, 6'h14, 1'b1, 8'h54, 3'b000, 3'b001, 1'b0, 1'b1, 1'b1, 8'h54};
        vecs[10] = '{1'b1, 6'h2A, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 8'h54};
        vecs[11] = '{1'b1, 6'h3F, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 8'h54};
        vecs[12] = '{1'b0, 6'h00, 1'b1, 8'hA3, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 8'hA3};
        vecs[13] = '{1'b1, 6'h06, 1'b1, 8'h81, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 8'h81};
        vecs[14] = '{1'b1, 6'h07, 1'b0, 8'h00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 8'h81};

        // Reset state, both while held and after release.
        repeat (3) step();
        checkOutput("reset_held", observed(), 32'd0);
        checkOutput("reset_iob", {28'd0, clkEna, bx0, bxRst, l1aRst}, 32'd0);
        rst = 1'b0;
        repeat (2) step();
        checkOutput("reset_released", observed(), 32'd0);

        // Inverted, registered copies of the backplane level lines.
        clkEnaIn = 1'b0;
        step();
        checkOutput("iob_clkena", {28'd0, clkEna, bx0, bxRst, l1aRst}, 32'h8);
        clkEnaIn = 1'b0; bx0In = 1'b0; bxRstIn = 1'b0; l1aRstIn = 1'b0;
        step();
        checkOutput("iob_all", {28'd0, clkEna, bx0, bxRst, l1aRst}, 32'hF);
        clkEnaIn = 1'b1; bx0In = 1'b1; bxRstIn = 1'b1; l1aRstIn = 1'b1;
        step();
        checkOutput("iob_none", {28'd0, clkEna, bx0, bxRst, l1aRst}, 32'h0);

        // Table: strobe one cycle, pulse appears one edge after the sampling edge, then clears.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].cmdStrb, vecs[i].cmd, vecs[i].dataStrb, vecs[i].data);
            step();
            applyStimulus(1'b0, 6'h00, 1'b0, 8'h00);
            checkOutput($sformatf("vec%0d_early", i), observed(),
                        packExp(3'b000, vecs[i].expRun ^ (vecs[i].expCmdPulse[1] | vecs[i].expCmdPulse[0]),
                                3'b000, 1'b0, 1'b0,
                                (vecs[i].expVld ? (i == 0 ? 8'h00 : vecs[i-1].expData) : vecs[i].expData),
                                2'b00));
            step();
            checkOutput($sformatf("vec%0d_pulse", i), observed(),
                        packExp(vecs[i].expCmdPulse, vecs[i].expRun, vecs[i].expTtc,
                                vecs[i].expVld, vecs[i].expDrst, vecs[i].expData, 2'b00));
            step();
            checkOutput($sformatf("vec%0d_after", i), observed(),
                        packExp(3'b000, vecs[i].expRun, 3'b000, 1'b0, 1'b0, vecs[i].expData, 2'b00));
        end

        // Strobe held five cycles yields exactly one START and sets RUN.
        pulseCnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            applyStimulus(cyc < 5, 6'h06, 1'b0, 8'h00);
            step();
            if (startTrg) pulseCnt++;
        end
        checkOutput("held_start_count", 32'(pulseCnt), 32'd1);
        checkOutput("held_start_run", {31'd0, run}, 32'd1);
        pulseCnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            applyStimulus(cyc < 4, 6'h07, 1'b0, 8'h00);
            step();
            if (stopTrg) pulseCnt++;
        end
        checkOutput("held_stop_count", 32'(pulseCnt), 32'd1);
        checkOutput("held_stop_run", {31'd0, run}, 32'd0);

        // Held data strobe captures once.
        pulseCnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            applyStimulus(1'b0, 6'h00, cyc < 4, 8'h55);
            step();
            if (dataVld) pulseCnt++;
        end
        checkOutput("held_data_count", 32'(pulseCnt), 32'd1);
        checkOutput("held_data_value", {24'd0, dataOut}, 32'h55);

        // Stretched pulses: 16 cycles, and 26 with a retrigger ten cycles in.
        runStretch("str0", 0, 6'h03, 1'b0, 16);
        runStretch("str0_retrig", 0, 6'h03, 1'b1, 26);
        runStretch("str1", 1, 6'h04, 1'b0, 16);

        // Reset five cycles into an SRST[1] pulse while the strobe is still held.
        applyStimulus(1'b1, 6'h06, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 6'h00, 1'b0, 8'h00);
        repeat (3) step();
        applyStimulus(1'b1, 6'h04, 1'b0, 8'h00);
        seenAt = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            if (srst[1]) begin
                seenAt = cyc;
                break;
            end
        end
        checkOutput("rstmid_pulse_seen", 32'(seenAt >= 0), 32'd1);
        checkOutput("rstmid_run_before", {31'd0, run}, 32'd1);
        repeat (4) step();
        rst = 1'b1;
        #1;
        checkOutput("rstmid_immediate", observed(), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        acc = 32'd0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            acc |= observed();
        end
        checkOutput("rstmid_no_retake", acc, 32'd0);
        applyStimulus(1'b0, 6'h00, 1'b0, 8'h00);
        repeat (3) step();
        runStretch("rstmid_fresh", 1, 6'h04, 1'b0, 16);

        // Unused codes produce no output change.
        for (int n = 0; n < 8; n++) begin
            code = 6'($urandom_range(0, 63));
            for (int tries = 0; tries < 64 && isUsedCode(code); tries++) begin
                code = code + 6'd1;
            end
            applyStimulus(1'b1, code, 1'b0, 8'h00);
            step();
            applyStimulus(1'b0, 6'h00, 1'b0, 8'h00);
            acc = 32'd0;
            for (int cyc = 0; cyc < 3; cyc++) begin
                step();
                acc |= observed();
            end
            checkOutput($sformatf("unused_0x%02h", code), acc, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
